mem_writeback: RTL and testbench

- Memory/writeback stage of the 5-stage RV32I core; sits after execute.
- Accepts the execute result and control bits, performs data-memory loads/stores over a req/ack handshake, and drives the register-file write port (rd_en, rd_data, rd_address) back into the decode stage.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_writeback.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_writeback.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// mem_writeback: memory/writeback stage of the RV32I pipeline (dmem req/ack, register-file write port).
// Build macro MISALIGN_CHECK_EN: reject misaligned halfword/word accesses and pulse misalign.
module mem_writeback #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exec_valid,
  input  logic [SIZE-1:0] alu_result,
  input  logic [SIZE-1:0] store_data,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      funct3_in,
  input  logic            wr_to_rf_in,
  input  logic            mem_write_in,
  input  logic            wb_select_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [SIZE-1:0] dmem_addr,
  output logic [SIZE-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic [SIZE-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            rd_en,
  output logic [SIZE-1:0] rd_data,
  output logic [4:0]      rd_address,
  output logic            mem_stall,
  output logic            misalign
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  function automatic logic [1:0] access_width(input logic is_store, input logic [2:0] f3);
    logic [1:0] w;
    if (is_store) begin
      case (f3)
        3'd0:    w = W_BYTE;
        3'd1:    w = W_HALF;
        default: w = W_WORD;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: w = W_BYTE;
        3'd1, 3'd5: w = W_HALF;
        default:    w = W_WORD;
      endcase
    end
    return w;
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    v = {{24{b[7]}}, b};
      3'd4:    v = {24'h00_0000, b};
      3'd1:    v = {{16{h[15]}}, h};
      3'd5:    v = {16'h0000, h};
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (access_width(1'b1, f3))
      W_BYTE:  s = 4'b0001 << off;
      W_HALF:  s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [2:0] f3);
    logic [31:0] d;
    case (access_width(1'b1, f3))
      W_BYTE:  d = {4{data[7:0]}};
      W_HALF:  d = {2{data[15:0]}};
      default: d = data;
    endcase
    return d;
  endfunction

`ifdef MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic m;
    case (access_width(is_store, f3))
      W_BYTE:  m = 1'b0;
      W_HALF:  m = off[0];
      default: m = (off != 2'd0);
    endcase
    return m;
  endfunction
`endif

  logic [0:0]      r_state;
  logic            r_is_load;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [4:0]      r_rd;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [SIZE-1:0] r_dmem_addr;
  logic [SIZE-1:0] r_dmem_wdata;
  logic [3:0]      r_dmem_wstrb;
  logic            r_rd_en;
  logic [SIZE-1:0] r_rd_data;
  logic [4:0]      r_rd_address;
  logic            r_hold_vld;
  logic [4:0]      r_hold_rd;
  logic [SIZE-1:0] r_hold_data;

  logic            w_stall;
  logic            w_accept;
  logic            w_is_mem;
  logic            w_misaligned;
  logic            w_issue;
  logic            w_alu_wr;
  logic            w_retire;
  logic            w_load_wr;
  logic [1:0]      w_off;
  logic [SIZE-1:0] w_load_data;

  assign w_off       = alu_result[1:0];
  assign w_stall     = (r_state == S_WAIT) & ~dmem_ack;
  assign w_accept    = exec_valid & ~w_stall;
  assign w_is_mem    = wb_select_in | mem_write_in;
`ifdef MISALIGN_CHECK_EN
  assign w_misaligned = is_misaligned(mem_write_in, funct3_in, w_off);
`else
  assign w_misaligned = 1'b0;
`endif
  assign w_issue     = w_accept & w_is_mem & ~w_misaligned;
  assign w_alu_wr    = w_accept & ~w_is_mem & wr_to_rf_in & (rd_in != 5'd0);
  assign w_retire    = (r_state == S_WAIT) & dmem_ack;
  assign w_load_wr   = w_retire & r_is_load & (r_rd != 5'd0);
  assign w_load_data = load_align(dmem_rdata, r_funct3, r_off);

  // Request FSM: a new access issued in the ack cycle replaces the finished one directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_rd         <= 5'd0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_wstrb <= 4'b0000;
    end else if (w_issue) begin
      r_state      <= S_WAIT;
      r_is_load    <= ~mem_write_in;
      r_funct3     <= funct3_in;
      r_off        <= w_off;
      r_rd         <= rd_in;
      r_dmem_req   <= 1'b1;
      r_dmem_we    <= mem_write_in;
      r_dmem_addr  <= {alu_result[SIZE-1:2], 2'b00};
      r_dmem_wdata <= mem_write_in ? store_lanes(store_data, funct3_in) : '0;
      r_dmem_wstrb <= mem_write_in ? store_strb(funct3_in, w_off) : 4'b0000;
    end else if (w_retire) begin
      r_state      <= S_IDLE;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_wstrb <= 4'b0000;
    end
  end

  // Write port: a retiring load takes the slot; an ALU result issued alongside waits one cycle in hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en      <= 1'b0;
      r_rd_data    <= '0;
      r_rd_address <= 5'd0;
      r_hold_vld   <= 1'b0;
      r_hold_rd    <= 5'd0;
      r_hold_data  <= '0;
    end else if (w_load_wr) begin
      r_rd_en      <= 1'b1;
      r_rd_data    <= w_load_data;
      r_rd_address <= r_rd;
      r_hold_vld   <= w_alu_wr;
      r_hold_rd    <= rd_in;
      r_hold_data  <= alu_result;
    end else if (r_hold_vld) begin
      r_rd_en      <= 1'b1;
      r_rd_data    <= r_hold_data;
      r_rd_address <= r_hold_rd;
      r_hold_vld   <= w_alu_wr;
      r_hold_rd    <= rd_in;
      r_hold_data  <= alu_result;
    end else begin
      r_rd_en <= w_alu_wr;
      if (w_alu_wr) begin
        r_rd_data    <= alu_result;
        r_rd_address <= rd_in;
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic r_misalign;

  // One-cycle pulse for an access rejected as misaligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept & w_is_mem & w_misaligned;
    end
  end

  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign dmem_wstrb = r_dmem_wstrb;
  assign rd_en      = r_rd_en;
  assign rd_data    = r_rd_data;
  assign rd_address = r_rd_address;
  assign mem_stall  = w_stall;

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: directed scenarios plus random traffic against a
// behavioural model; a negedge monitor pops expected register writes and memory requests.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        exec_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        wr_to_rf_in;
  logic        mem_write_in;
  logic        wb_select_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [4:0]  rd_address;
  logic        mem_stall;
  logic        misalign;

  mem_writeback #(.SIZE(32)) dut (
    .clk(clk), .reset(reset), .exec_valid(exec_valid), .alu_result(alu_result),
    .store_data(store_data), .rd_in(rd_in), .funct3_in(funct3_in), .wr_to_rf_in(wr_to_rf_in),
    .mem_write_in(mem_write_in), .wb_select_in(wb_select_in), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .rd_en(rd_en), .rd_data(rd_data),
    .rd_address(rd_address), .mem_stall(mem_stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb; } req_t;

  wb_t         rdq[$];
  req_t        reqq[$];
  logic [31:0] mem [64];
  int          errors = 0;
  int          checks = 0;
  int          mis_pending = 0;
  int          mis_seen = 0;
  int          forced_dly = -1;
  int          req_cycles = 0;
  int          stall_cycles = 0;
  int          rd_pulses = 0;
  logic [31:0] last_req_addr = 32'd0;
  logic [31:0] last_req_wdata = 32'd0;
  logic [3:0]  last_req_wstrb = 4'd0;
  logic        last_req_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] o);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * o)) & 32'h0000_00FF;
    h = (w >> (16 * o[1])) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic expect_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                           input logic [2:0] f3, input logic wr, input logic mw, input logic ws);
    req_t r;
    if (!mw && !ws) begin
      if (wr && rd != 5'd0) rdq.push_back('{rd, alu});
      return;
    end
`ifdef MISALIGN_CHECK_EN
    begin
      int sz;
      if (mw) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      else    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      if ((alu % 32'(sz)) != 32'd0) begin
        mis_pending++;
        return;
      end
    end
`endif
    r.addr  = alu & 32'hFFFF_FFFC;
    r.we    = mw;
    r.wdata = 32'd0;
    r.wstrb = 4'd0;
    if (mw) begin
      if (f3 == 3'd0) begin
        r.wstrb = 4'(1 << alu[1:0]);
        r.wdata = (sd & 32'hFF) * 32'h0101_0101;
      end else if (f3 == 3'd1) begin
        r.wstrb = alu[1] ? 4'd12 : 4'd3;
        r.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        r.wstrb = 4'd15;
        r.wdata = sd;
      end
    end else if (rd != 5'd0) begin
      rdq.push_back('{rd, model_load(mem[alu[7:2]], f3, alu[1:0])});
    end
    reqq.push_back(r);
  endtask

  task automatic junk();
    alu_result   = $urandom;
    store_data   = $urandom;
    rd_in        = 5'($urandom);
    funct3_in    = 3'($urandom);
    wr_to_rf_in  = 1'($urandom);
    mem_write_in = 1'($urandom);
    wb_select_in = 1'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that accepted the operation.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic [2:0] f3, input logic wr, input logic mw, input logic ws);
    int guard;
    exec_valid = 1'b1; alu_result = alu; store_data = sd; rd_in = rd; funct3_in = f3;
    wr_to_rf_in = wr; mem_write_in = mw; wb_select_in = ws;
    guard = 0;
    @(negedge clk); #1;
    while (mem_stall && guard < 50) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      guard++;
    end
    if (mem_stall) begin
      checks++; errors++;
      $display("FAIL issue_timeout: mem_stall=1 after %0d cycles, expected 0", guard);
    end else begin
      expect_op(alu, sd, rd, f3, wr, mw, ws);
    end
    @(posedge clk); #1;
    exec_valid = 1'b0;
    junk();
  endtask

  task automatic idle(input int n);
    exec_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      junk();
    end
  endtask

  task automatic wait_rd(output logic [31:0] data, output logic [4:0] addr);
    bit got;
    got = 0; data = 32'd0; addr = 5'd0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #3;
      if (rd_en) begin
        got = 1; data = rd_data; addr = rd_address;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_rd_timeout: rd_en=0 for 20 cycles, expected a pulse");
    end
    @(posedge clk); #1;
  endtask

  // Memory responder: acks after a per-request delay, returning the word from mem[].
  initial begin
    int dly;
    bit busy;
    dly = 0; busy = 0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (dmem_req && !reset) begin
        if (!busy) begin
          busy = 1;
          dly = (forced_dly >= 0) ? forced_dly : $urandom_range(0, 3);
        end
        if (dly == 0) begin
          dmem_ack = 1'b1; dmem_rdata = mem[dmem_addr[7:2]]; busy = 0;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom; dly--;
        end
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom; busy = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request or a register write.
  initial begin
    logic        p_req, p_ack;
    logic [31:0] p_addr;
    logic [3:0]  p_wstrb;
    req_t        r;
    wb_t         w;
    p_req = 1'b0; p_ack = 1'b0; p_addr = 32'd0; p_wstrb = 4'd0;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        check("mem_stall", 32'(mem_stall), 32'(dmem_req & ~dmem_ack));
        if (dmem_req)  req_cycles++;
        if (mem_stall) stall_cycles++;
        if (dmem_req && (!p_req || p_ack)) begin
          last_req_addr = dmem_addr; last_req_we = dmem_we;
          last_req_wdata = dmem_wdata; last_req_wstrb = dmem_wstrb;
          if (reqq.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: dmem_req=1 addr 0x%08h, expected no request", dmem_addr);
          end else begin
            r = reqq.pop_front();
            check("dmem_addr", dmem_addr, r.addr);
            check("dmem_we", 32'(dmem_we), 32'(r.we));
            check("dmem_wstrb", 32'(dmem_wstrb), 32'(r.wstrb));
            if (r.we) check("dmem_wdata", dmem_wdata, r.wdata);
          end
        end else if (dmem_req) begin
          check("req_hold_addr", dmem_addr, p_addr);
          check("req_hold_wstrb", 32'(dmem_wstrb), 32'(p_wstrb));
        end
        if (rd_en) begin
          rd_pulses++;
          if (rdq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: rd_en=1 rd %0d data 0x%08h, expected rd_en=0",
                     rd_address, rd_data);
          end else begin
            w = rdq.pop_front();
            check("rd_address", 32'(rd_address), 32'(w.rd));
            check("rd_data", rd_data, w.data);
          end
        end
        if (misalign) begin
          mis_seen++;
          checks++;
          if (mis_pending == 0) begin
            errors++;
            $display("FAIL misalign_unexpected: misalign=1, expected 0");
          end else begin
            mis_pending--;
          end
        end
      end
      p_req = dmem_req; p_ack = dmem_ack; p_addr = dmem_addr; p_wstrb = dmem_wstrb;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, d1;
    logic [4:0]  a0;
    logic [31:0] pd[$];
    logic [4:0]  pa[$];
    int          pc[$];
    int          base;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h80FF_1234;
    reset = 1'b1; exec_valid = 1'b0; junk();
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    check("reset_rd_en", 32'(rd_en), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_rd_address", 32'(rd_address), 32'd0);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);
    check("reset_dmem_we", 32'(dmem_we), 32'd0);
    check("reset_dmem_addr", dmem_addr, 32'd0);
    check("reset_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    check("reset_mem_stall", 32'(mem_stall), 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addi x3 = 5
    stall_cycles = 0;
    issue(32'h0000_0005, 32'd0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #3;
    check("addi_rd_en", 32'(rd_en), 32'd1);
    check("addi_rd_address", 32'(rd_address), 32'd3);
    check("addi_rd_data", rd_data, 32'd5);
    @(posedge clk); #1;
    idle(2);
    check("addi_no_stall", 32'(stall_cycles), 32'd0);

    // LB / LBU at 0x103, ack in the third WAIT cycle
    forced_dly = 2;
    for (int k = 0; k < 2; k++) begin
      req_cycles = 0; stall_cycles = 0;
      issue(32'h0000_0103, 32'd0, 5'd7, (k == 0) ? 3'd0 : 3'd4, 1'b1, 1'b0, 1'b1);
      wait_rd(d0, a0);
      check("lb_req_cycles", 32'(req_cycles), 32'd3);
      check("lb_stall_cycles", 32'(stall_cycles), 32'd2);
      check("lb_dmem_addr", last_req_addr, 32'h0000_0100);
      check("lb_rd_data", d0, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      idle(1);
    end
    forced_dly = -1;

    // SH at 0x202
    base = rd_pulses;
    issue(32'h0000_0202, 32'hAAAA_BEEF, 5'd9, 3'd1, 1'b0, 1'b1, 1'b0);
    idle(8);
    check("sh_we", 32'(last_req_we), 32'd1);
    check("sh_wstrb", 32'(last_req_wstrb), 32'b1100);
    check("sh_wdata", last_req_wdata, 32'hBEEF_BEEF);
    check("sh_no_rd_en", 32'(rd_pulses - base), 32'd0);

    // Back-to-back: load acked at once, addi issued in the ack cycle
    forced_dly = 0;
    issue(32'h0000_001C, 32'd0, 5'd4, 3'd2, 1'b1, 1'b0, 1'b1);
    issue(32'h0000_1234, 32'd0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #3;
      if (rd_en) begin pd.push_back(rd_data); pa.push_back(rd_address); pc.push_back(i); end
    end
    @(posedge clk); #1;
    check("b2b_pulses", 32'(pd.size()), 32'd2);
    if (pd.size() == 2) begin
      check("b2b_load_rd", 32'(pa[0]), 32'd4);
      check("b2b_load_data", pd[0], mem[7]);
      check("b2b_addi_rd", 32'(pa[1]), 32'd5);
      check("b2b_addi_data", pd[1], 32'h0000_1234);
      check("b2b_consecutive", 32'(pc[1] - pc[0]), 32'd1);
    end
    forced_dly = -1;

    // Load to x0
    req_cycles = 0; base = rd_pulses;
    issue(32'h0000_0010, 32'd0, 5'd0, 3'd2, 1'b1, 1'b0, 1'b1);
    idle(8);
    check("x0_req_issued", 32'(req_cycles != 0), 32'd1);
    check("x0_no_rd_en", 32'(rd_pulses - base), 32'd0);

    // Reset while waiting for ack
    forced_dly = 3; base = rd_pulses;
    issue(32'h0000_0040, 32'd0, 5'd6, 3'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk); #3;
    check("rstwait_in_wait", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    rdq.delete(); reqq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #3;
    check("rstwait_req_dropped", 32'(dmem_req), 32'd0);
    check("rstwait_no_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    idle(6);
    check("rstwait_no_rd_en", 32'(rd_pulses - base), 32'd0);
    forced_dly = -1;

    // LW at 0x301
    req_cycles = 0; base = mis_seen;
`ifdef MISALIGN_CHECK_EN
    issue(32'h0000_0301, 32'd0, 5'd8, 3'd2, 1'b1, 1'b0, 1'b1);
    idle(6);
    check("lw_mis_pulse", 32'(mis_seen - base), 32'd1);
    check("lw_mis_no_req", 32'(req_cycles), 32'd0);
`else
    issue(32'h0000_0301, 32'd0, 5'd8, 3'd2, 1'b1, 1'b0, 1'b1);
    wait_rd(d1, a0);
    check("lw_addr_masked", last_req_addr, 32'h0000_0300);
    check("lw_rd_address", 32'(a0), 32'd8);
    check("lw_rd_data", d1, mem[0]);
    check("lw_no_misalign", 32'(mis_seen - base), 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4)
        issue($urandom, $urandom, 5'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      else if (kind < 7)
        issue($urandom, $urandom, 5'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b1);
      else
        issue($urandom, $urandom, 5'($urandom), 3'($urandom), 1'b0, 1'b1, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(20);
    check("drain_rdq", 32'(rdq.size()), 32'd0);
    check("drain_reqq", 32'(reqq.size()), 32'd0);
    check("drain_misalign", 32'(mis_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
